// File: rtl/sha256_host_ctrl.sv
// Host-side job controller for the SHA-256 core. It streams the message into shared memory,
// pulses start, waits for the core's done level to fall and rise again, then reads the eight
// hash words back and streams them out. The memory port belongs to the core from start until
// done returns; this block owns it the rest of the time.
module sha256_host_ctrl #(
    parameter int unsigned NUM_OF_WORDS = 40,
    parameter logic [15:0] INPUT_ADDR   = 16'h0000,
    parameter logic [15:0] HASH_ADDR    = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,
    // message word stream
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    // hash word stream
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    // core control
    output logic        sha_start,
    input  logic        sha_done,
    output logic [15:0] sha_input_addr,
    output logic [15:0] sha_hash_addr,
    // shared memory port
    output logic        mem_sel,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StWaitBusy,
        StWaitDone,
        StRdReq,
        StRdCap,
        StOut
    } state_e;

    localparam logic [10:0] LastWord = 11'(NUM_OF_WORDS - 1);
    localparam logic [2:0]  LastHash = 3'd7;

    state_e      state_q, state_d;
    logic [10:0] wcnt_q, wcnt_d;
    logic [2:0]  hcnt_q, hcnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic        in_ready_q, in_ready_d;
    logic        word_accept;

    // in_ready_q is only ever high in StLoad, so it also qualifies the accept
    assign word_accept = in_valid & in_ready_q;

    // Next-state, counter and capture logic for the job sequence
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        hcnt_d     = hcnt_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StLoad: begin
                if (word_accept) begin
                    if (wcnt_q == LastWord) begin
                        state_d = StStart;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 11'd1;
                    end
                end
            end
            StStart: begin
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // done is still high from the idle core on entry; only its fall arms completion
                if (!sha_done) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (sha_done) begin
                    state_d = StRdReq;
                    hcnt_d  = '0;
                end
            end
            StRdReq: begin
                state_d = StRdCap;
            end
            StRdCap: begin
                out_data_d = mem_read_data;
                state_d    = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    if (hcnt_q == LastHash) begin
                        state_d = StLoad;
                        hcnt_d  = '0;
                    end else begin
                        state_d = StRdReq;
                        hcnt_d  = hcnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
        in_ready_d = (state_d == StLoad);
    end

    // State and datapath registers; reset abandons any job in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            wcnt_q     <= '0;
            hcnt_q     <= '0;
            out_data_q <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            hcnt_q     <= hcnt_d;
            out_data_q <= out_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Output decode from the registered state and counters
    always_comb begin
        in_ready       = in_ready_q;
        out_valid      = (state_q == StOut);
        out_data       = out_data_q;
        sha_start      = (state_q == StStart);
        sha_input_addr = INPUT_ADDR;
        sha_hash_addr  = HASH_ADDR;
        mem_sel        = !((state_q == StStart) || (state_q == StWaitBusy) ||
                           (state_q == StWaitDone));
        mem_we         = word_accept;
        mem_write_data = in_data;
        if ((state_q == StRdReq) || (state_q == StRdCap) || (state_q == StOut)) begin
            mem_addr = HASH_ADDR + {13'd0, hcnt_q};
        end else begin
            mem_addr = INPUT_ADDR + {5'd0, wcnt_q};
        end
    end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Self-checking bench for sha256_host_ctrl: memory model, simple core model, and scoreboards
// for memory writes and hash output words.
module tb_sha256_host_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        sha_start;
    logic        sha_done;
    logic [15:0] sha_input_addr;
    logic [15:0] sha_hash_addr;
    logic        mem_sel;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int total = 0;
    int bad   = 0;

    logic [47:0] wq[$];   // expected {addr, data} writes
    logic [31:0] oq[$];   // expected hash output words
    logic [31:0] mem [65536];
    logic [31:0] hash_seed = 32'h0;
    int          core_cnt;
    int          out_hs = 0;

    sha256_host_ctrl #(
        .NUM_OF_WORDS(40),
        .INPUT_ADDR  (16'h0000),
        .HASH_ADDR   (16'h0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .sha_start     (sha_start),
        .sha_done      (sha_done),
        .sha_input_addr(sha_input_addr),
        .sha_hash_addr (sha_hash_addr),
        .mem_sel       (mem_sel),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: done high 3 cycles after start, low 50 cycles, then high; writes hash words
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha_done <= 1'b1;
            core_cnt <= -1;
        end else if (sha_start) begin
            core_cnt <= 0;
        end else if (core_cnt >= 0) begin
            if (core_cnt == 2) sha_done <= 1'b0;
            if (core_cnt == 52) begin
                sha_done <= 1'b1;
                core_cnt <= -1;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    // Shared memory: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_sel) begin
            if (mem_we) mem[mem_addr] <= mem_write_data;
            mem_read_data <= mem[mem_addr];
        end else if (core_cnt >= 10 && core_cnt < 18) begin
            mem[16'h0100 + 16'(core_cnt - 10)] <= hash_seed + 32'(core_cnt - 10);
        end
    end

    // Monitor on the falling edge: write and output scoreboards, ownership and pulse checks
    initial begin
        logic [47:0] exp_w;
        logic [31:0] exp_o;
        logic [31:0] held;
        logic        prev_stall;
        logic        prev_start;
        prev_stall = 1'b0;
        prev_start = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                total++;
                if (mem_we !== (in_valid & in_ready)) begin
                    bad++;
                    $display("FAIL we_gate: mem_we=%b required %b", mem_we, in_valid & in_ready);
                end
                if (mem_sel && mem_we) begin
                    total++;
                    if (wq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write: addr=%h data=%h required none",
                                 mem_addr, mem_write_data);
                    end else begin
                        exp_w = wq.pop_front();
                        if ({mem_addr, mem_write_data} !== exp_w) begin
                            bad++;
                            $display("FAIL write: addr/data=%h/%h required %h/%h", mem_addr,
                                     mem_write_data, exp_w[47:32], exp_w[31:0]);
                        end
                    end
                end
                if (core_cnt >= 0) begin
                    total++;
                    if (mem_sel !== 1'b0) begin
                        bad++;
                        $display("FAIL core_owns_mem: mem_sel=%b required 0", mem_sel);
                    end
                end
                if (sha_start) begin
                    total++;
                    if (prev_start) begin
                        bad++;
                        $display("FAIL start_pulse: sha_start=1 two cycles running, required 1");
                    end
                end
                prev_start = sha_start;
                if (prev_stall && out_valid) begin
                    total++;
                    if (out_data !== held) begin
                        bad++;
                        $display("FAIL stall_stable: out_data=%h required %h", out_data, held);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    if (oq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: out_data=%h required none", out_data);
                    end else begin
                        exp_o = oq.pop_front();
                        if (out_data !== exp_o) begin
                            bad++;
                            $display("FAIL out_word%0d: out_data=%h required %h", out_hs,
                                     out_data, exp_o);
                        end
                    end
                    out_hs++;
                end
                prev_stall = out_valid && !out_ready;
                held       = out_data;
            end else begin
                prev_stall = 1'b0;
                prev_start = 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, sha_start, mem_we, mem_sel} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_ctrl: rdy/ov/start/we/sel=%b required 00001",
                     {in_ready, out_valid, sha_start, mem_we, mem_sel});
        end
        total++;
        if ({mem_addr, out_data, mem_write_data} !== {16'h0000, 32'h0, 32'h1234_5678}) begin
            bad++;
            $display("FAIL reset_data: addr=%h out=%h wdata=%h required 0000 0 12345678",
                     mem_addr, out_data, mem_write_data);
        end
        total++;
        if ({sha_input_addr, sha_hash_addr} !== {16'h0000, 16'h0100}) begin
            bad++;
            $display("FAIL reset_const: in/hash addr=%h/%h required 0000/0100",
                     sha_input_addr, sha_hash_addr);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || mem_addr !== 16'h0000) begin
            bad++;
            $display("FAIL after_release: in_ready=%b addr=%h required 1 0000", in_ready,
                     mem_addr);
        end
    endtask

    // Loads 40 words (base+k); expected hash words seed+k pushed as the job is issued
    task automatic test_load(input logic [31:0] base, input logic [31:0] seed, input bit gaps);
        int k   = 0;
        int cyc = 0;
        hash_seed = seed;
        for (int j = 0; j < 8; j++) oq.push_back(seed + 32'(j));
        while (k < 40) begin
            if (gaps && (cyc % 3 == 2)) begin
                in_valid = 1'b0;
            end else begin
                total++;
                if (in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL load_ready: word %0d in_ready=%b required 1", k, in_ready);
                end
                in_valid = 1'b1;
                in_data  = base + 32'(k);
                wq.push_back({16'(k), base + 32'(k)});
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if ({sha_start, mem_sel, in_ready} !== 3'b100 || wq.size() != 0) begin
            bad++;
            $display("FAIL start_cycle: start/sel/rdy=%b pending=%0d required 100 0",
                     {sha_start, mem_sel, in_ready}, wq.size());
        end
        @(posedge clk);
        #1;
        total++;
        if ({sha_start, mem_sel} !== 2'b00) begin
            bad++;
            $display("FAIL after_start: start/sel=%b required 00", {sha_start, mem_sel});
        end
    endtask

    // Waits for done to fall and rise, then checks the first hash read request
    task automatic test_done_seq();
        int n = 0;
        while (sha_done !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sha_done !== 1'b0) begin
            bad++;
            $display("FAIL done_fall: sha_done=%b required 0 within 20 cycles", sha_done);
        end
        n = 0;
        while (sha_done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sha_done !== 1'b1 || mem_sel !== 1'b0) begin
            bad++;
            $display("FAIL done_rise: done/sel=%b%b required 10", sha_done, mem_sel);
        end
        @(posedge clk);
        #1;
        total++;
        if ({mem_sel, mem_we, mem_addr} !== {2'b10, 16'h0100}) begin
            bad++;
            $display("FAIL first_rd_req: sel/we/addr=%b%b/%h required 10/0100", mem_sel,
                     mem_we, mem_addr);
        end
    endtask

    // Entered in the first read-request cycle; drains all 8 hash words
    task automatic test_readback(input bit bp);
        int cyc   = 0;
        int stall = 0;
        out_hs = 0;
        while (out_hs < 8 && cyc < 400) begin
            if (!bp) begin
                out_ready = 1'b1;
            end else if (out_hs == 3 && out_valid && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ~out_ready;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        total++;
        if (out_hs != 8 || in_ready !== 1'b1 || oq.size() != 0) begin
            bad++;
            $display("FAIL readback_end: words=%0d in_ready=%b left=%0d required 8 1 0",
                     out_hs, in_ready, oq.size());
        end
        if (!bp) begin
            total++;
            if (cyc != 24) begin
                bad++;
                $display("FAIL readback_cycles: cycles=%0d required 24", cyc);
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        test_load(32'hB000_0000, 32'h3333_0000, 1'b0);
        while (sha_done !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, sha_start, mem_we, mem_sel, mem_addr} !==
            {5'b00001, 16'h0000}) begin
            bad++;
            $display("FAIL async_reset: rdy/ov/start/we/sel=%b addr=%h required 00001 0000",
                     {in_ready, out_valid, sha_start, mem_we, mem_sel}, mem_addr);
        end
        oq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || mem_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_reload: in_ready=%b addr=%h required 1 0000", in_ready,
                     mem_addr);
        end
        test_load(32'hC000_0000, 32'h4444_0000, 1'b1);
        test_done_seq();
        test_readback(1'b0);
    endtask

    initial begin
        test_reset();
        test_load(32'hA000_0000, 32'h1111_0000, 1'b1);
        test_done_seq();
        test_readback(1'b1);
        // back-to-back job straight after the previous one, full throughput
        test_load(32'h5000_0000, 32'h2222_0000, 1'b0);
        test_done_seq();
        test_readback(1'b0);
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
